// File: rtl/ifid_skid_reg.sv
// IF/ID boundary register: valid/ready on both sides, two-entry skid, synchronous flush.
// Latency: one cycle from accept to out_valid; full throughput with out_ready held high.
// Backpressure: in_ready (a register bit) drops the cycle after skid fills; skid holds the in-flight entry.
module ifid_skid_reg #(
  parameter int                 INSTR_W   = 16,
  parameter int                 PC_W      = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(16'h0800)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_curr_pc,
  input  logic [PC_W-1:0]    in_next_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_curr_pc,
  output logic [PC_W-1:0]    out_next_pc
);

  // One pipeline entry as carried across the boundary.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    curr_pc;
    logic [PC_W-1:0]    next_pc;
  } entry_t;

  // Contents of an empty slot: decode sees a NOP with zeroed PCs.
  localparam entry_t BUBBLE = '{instr: NOP_INSTR, curr_pc: '0, next_pc: '0};

  // State encoding is {main_valid, skid_valid}, so the valid bits fall out of the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_ent;
  logic   in_fire;
  logic   out_fire;

  assign in_ent = '{instr: in_instr, curr_pc: in_curr_pc, next_pc: in_next_pc};

  // Outputs come straight from flops; no input reaches an output combinationally.
  assign out_valid   = state[1];
  assign in_ready    = ~state[0];
  assign out_instr   = main_q.instr;
  assign out_curr_pc = main_q.curr_pc;
  assign out_next_pc = main_q.next_pc;

  // A flush cycle never accepts the offered entry.
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  // Slot/state update: reset, then flush, then the normal handshake transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else if (flush) begin
      // Redirect: everything held is dead; a same-cycle out_fire was already consumed by decode.
      state  <= EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= ONE;
            main_q <= in_ent;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_ent;
          end else if (in_fire) begin
            // Decode stalled: park the new entry behind main and stop accepting.
            state  <= FULL;
            skid_q <= in_ent;
          end else if (out_fire) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move things.
          if (out_fire) begin
            state  <= ONE;
            main_q <= skid_q;
            skid_q <= BUBBLE;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= BUBBLE;
          skid_q <= BUBBLE;
        end
      endcase
    end
  end

endmodule
